// File: rtl/sequenceur_chute_pkg.sv
// Shared definitions for the falling-brick game controller:
// state codes, column codes, limits and the height update rule.
package sequenceur_chute_pkg;

    typedef enum logic [1:0] {
        ATTENTE   = 2'd0,
        JEU       = 2'd1,
        NETTOYAGE = 2'd2,
        FIN       = 2'd3
    } etat_t;

    localparam logic [1:0] COL_GAUCHE = 2'd0;
    localparam logic [1:0] COL_CENTRE = 2'd1;
    localparam logic [1:0] COL_DROITE = 2'd2;

    localparam logic [2:0] HAUTEUR_MAX = 3'd7;
    localparam logic [7:0] SCORE_MAX   = 8'd255;
    localparam int unsigned PERIODE_DEF = 25_000_000;

    // A landing and a row clear in the same cycle cancel out.
    function automatic logic [2:0] hauteur_suivante(input logic [2:0] h,
                                                    input logic       plus,
                                                    input logic       moins);
        logic [2:0] r;
        r = h;
        if (plus && !moins && h != HAUTEUR_MAX)
            r = h + 3'd1;
        else if (moins && !plus && h != 3'd0)
            r = h - 3'd1;
        return r;
    endfunction

endpackage

// File: rtl/sequenceur_chute_detecteur_front.sv
// Rising-edge detector for one level button: one history flop,
// a held level produces a single event.
module detecteur_front (
    input  logic clk,
    input  logic reset,
    input  logic niveau,
    output logic front
);

    logic histo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            histo <= 1'b0;
        else
            histo <= niveau;
    end

    assign front = niveau & ~histo;

endmodule

// File: rtl/sequenceur_chute.sv
// Game controller: gravity tick, column steering, heights, row clear,
// score and loss freeze for the three-column falling-brick datapath.
module sequenceur_chute
    import sequenceur_chute_pkg::*;
#(
    parameter int unsigned PERIODE    = PERIODE_DEF,
    parameter logic [1:0]  COL_DEPART = COL_CENTRE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_gauche,
    input  logic       btn_droite,
    input  logic       btn_start,
    input  logic       plus_gauche,
    input  logic       plus_centre,
    input  logic       plus_droite,
    input  logic       aligne,
    input  logic       perdu,
    input  logic [2:0] row,
    output logic       pulse,
    output logic [1:0] col,
    output logic [2:0] hauteur_gauche,
    output logic [2:0] hauteur_centre,
    output logic [2:0] hauteur_droite,
    output logic [7:0] score,
    output logic [1:0] etat
);

    localparam int          CW      = (PERIODE > 1) ? $clog2(PERIODE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PERIODE - 1);

    etat_t           etat_q;
    logic [CW-1:0]   cnt;
    logic [2:0][2:0] haut;
    logic [2:0]      plus;
    logic            f_gauche, f_droite, f_start;
    logic [2:0]      cible_g, cible_d;
    logic            peut_gauche, peut_droite;

    detecteur_front u_front_gauche (.clk(clk), .reset(reset), .niveau(btn_gauche), .front(f_gauche));
    detecteur_front u_front_droite (.clk(clk), .reset(reset), .niveau(btn_droite), .front(f_droite));
    detecteur_front u_front_start  (.clk(clk), .reset(reset), .niveau(btn_start),  .front(f_start));

    assign plus = {plus_droite, plus_centre, plus_gauche};

    // Missing neighbour reads as full height so the move is always refused.
    always_comb begin
        cible_g = HAUTEUR_MAX;
        cible_d = HAUTEUR_MAX;
        case (col)
            COL_CENTRE: begin
                cible_g = haut[0];
                cible_d = haut[2];
            end
            COL_DROITE: cible_g = haut[1];
            COL_GAUCHE: cible_d = haut[1];
            default: ;
        endcase
    end

    assign peut_gauche = f_gauche & ~f_droite & (cible_g < row);
    assign peut_droite = f_droite & ~f_gauche & (cible_d < row);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            etat_q <= ATTENTE;
            cnt    <= '0;
            pulse  <= 1'b0;
            col    <= COL_DEPART;
            haut   <= '0;
            score  <= '0;
        end else begin
            pulse <= 1'b0;
            case (etat_q)
                ATTENTE: begin
                    if (f_start) begin
                        etat_q <= JEU;
                        cnt    <= '0;
                        col    <= COL_DEPART;
                        haut   <= '0;
                        score  <= '0;
                    end
                end
                JEU: begin
                    if (cnt == CNT_MAX) begin
                        cnt   <= '0;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (perdu)
                        etat_q <= FIN;
                    else if (aligne)
                        etat_q <= NETTOYAGE;
                    if (peut_gauche)
                        col <= col - 2'd1;
                    else if (peut_droite)
                        col <= col + 2'd1;
                end
                NETTOYAGE: begin
                    etat_q <= JEU;
                    if (score != SCORE_MAX)
                        score <= score + 8'd1;
                end
                FIN: begin
                    if (f_start)
                        etat_q <= ATTENTE;
                end
                default: etat_q <= ATTENTE;
            endcase

            // Landings override any steering decided above.
            if (etat_q == JEU || etat_q == NETTOYAGE) begin
                for (int i = 0; i < 3; i++)
                    haut[i] <= hauteur_suivante(haut[i], plus[i], etat_q == NETTOYAGE);
                if (|plus)
                    col <= COL_DEPART;
            end
        end
    end

    assign etat           = etat_q;
    assign hauteur_gauche = haut[0];
    assign hauteur_centre = haut[1];
    assign hauteur_droite = haut[2];

endmodule

// File: tb/tb_sequenceur_chute.sv
// Bench for sequenceur_chute: directed scenarios plus random play against
// a behavioural model of the game rules.
module tb_sequenceur_chute;

    localparam int PER = 4;
    localparam int COL = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bg = 0, bd = 0, bs = 0, pg = 0, pc = 0, pd = 0, al = 0, pe = 0;
    logic [2:0] row = 3'd7;
    logic       pulse;
    logic [1:0] col;
    logic [2:0] hg, hc, hd;
    logic [7:0] score;
    logic [1:0] etat;

    int nvec = 0;
    int nerr = 0;

    // behavioural model state
    int m_etat, m_cnt, m_pulse, m_col, m_score;
    int m_h[3];
    bit m_pb_g, m_pb_d, m_pb_s;

    sequenceur_chute #(.PERIODE(PER), .COL_DEPART(2'd1)) dut (
        .clk(clk), .reset(reset),
        .btn_gauche(bg), .btn_droite(bd), .btn_start(bs),
        .plus_gauche(pg), .plus_centre(pc), .plus_droite(pd),
        .aligne(al), .perdu(pe), .row(row),
        .pulse(pulse), .col(col),
        .hauteur_gauche(hg), .hauteur_centre(hc), .hauteur_droite(hd),
        .score(score), .etat(etat)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_etat = 0; m_cnt = 0; m_pulse = 0; m_col = COL; m_score = 0;
        m_h = '{0, 0, 0};
        m_pb_g = 0; m_pb_d = 0; m_pb_s = 0;
    endtask

    // One clock of the game rules, applied to the inputs currently driven.
    task automatic model_step();
        int nh[3];
        int ncol, ns, ne, nc, np;
        bit rg, rd, rs, anyp;
        bit pl[3];
        rg = bg && !m_pb_g;
        rd = bd && !m_pb_d;
        rs = bs && !m_pb_s;
        pl = '{pg, pc, pd};
        anyp = pg || pc || pd;
        nh = m_h; ncol = m_col; ns = m_score; ne = m_etat; nc = m_cnt; np = 0;
        if (m_etat == 0) begin
            if (rs) begin
                ne = 1; nh = '{0, 0, 0}; ns = 0; nc = 0; ncol = COL;
            end
        end else if (m_etat == 1) begin
            np = (m_cnt == PER - 1) ? 1 : 0;
            nc = (m_cnt + 1) % PER;
            ne = pe ? 3 : (al ? 2 : 1);
            if (rg && !rd && m_col > 0 && m_h[m_col-1] < int'(row)) ncol = m_col - 1;
            if (rd && !rg && m_col < 2 && m_h[m_col+1] < int'(row)) ncol = m_col + 1;
            for (int i = 0; i < 3; i++)
                if (pl[i]) nh[i] = (m_h[i] >= 7) ? 7 : m_h[i] + 1;
            if (anyp) ncol = COL;
        end else if (m_etat == 2) begin
            ne = 1;
            ns = (m_score >= 255) ? 255 : m_score + 1;
            for (int i = 0; i < 3; i++)
                if (!pl[i]) nh[i] = (m_h[i] > 0) ? m_h[i] - 1 : 0;
            if (anyp) ncol = COL;
        end else begin
            if (rs) ne = 0;
        end
        m_etat = ne; m_cnt = nc; m_pulse = np; m_col = ncol; m_score = ns; m_h = nh;
        m_pb_g = bg; m_pb_d = bd; m_pb_s = bs;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {bg, bd, bs, pg, pc, pd, al, pe} = '0;
        row = 3'd7;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic new_game();
        do_reset();
        bs = 1; step(); bs = 0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (etat !== 2'd0) begin nerr++; $display("FAIL reset_etat got %0d want 0", etat); end
        nvec++; if (pulse !== 1'b0) begin nerr++; $display("FAIL reset_pulse got %0b want 0", pulse); end
        nvec++; if (col !== 2'd1) begin nerr++; $display("FAIL reset_col got %0d want 1", col); end
        nvec++; if ({hg, hc, hd} !== 9'd0) begin nerr++; $display("FAIL reset_hauteurs got %0d/%0d/%0d want 0/0/0", hg, hc, hd); end
        nvec++; if (score !== 8'd0) begin nerr++; $display("FAIL reset_score got %0d want 0", score); end
        for (int i = 0; i < 6; i++) begin
            step();
            nvec++; if (pulse !== 1'b0 || etat !== 2'd0) begin nerr++; $display("FAIL attente_idle cyc %0d got pulse %0b etat %0d want 0/0", i, pulse, etat); end
        end
    endtask

    task automatic test_start_pulse();
        bs = 1; step(); bs = 0;
        nvec++; if (etat !== 2'd1) begin nerr++; $display("FAIL start_etat got %0d want 1", etat); end
        for (int k = 1; k <= 12; k++) begin
            step();
            nvec++; if (pulse !== ((k % 4) == 0)) begin nerr++; $display("FAIL tick_period k=%0d got %0b want %0b", k, pulse, (k % 4) == 0); end
        end
    endtask

    task automatic test_steering();
        int exp_col[3] = '{1, 2, 2};
        row = 3'd7;
        bg = 1; step();
        nvec++; if (col !== 2'd0) begin nerr++; $display("FAIL steer_left got %0d want 0", col); end
        for (int i = 0; i < 9; i++) step();
        nvec++; if (col !== 2'd0) begin nerr++; $display("FAIL steer_left_held got %0d want 0", col); end
        bg = 0; step(); bg = 1; step();
        nvec++; if (col !== 2'd0) begin nerr++; $display("FAIL steer_left_edge got %0d want 0", col); end
        bg = 0; step();
        for (int i = 0; i < 3; i++) begin
            bd = 1; step();
            nvec++; if (col !== 2'(exp_col[i])) begin nerr++; $display("FAIL steer_right_%0d got %0d want %0d", i, col, exp_col[i]); end
            bd = 0; step();
        end
    endtask

    task automatic test_blocked();
        new_game();
        pg = 1; step(); step(); step(); pg = 0;
        nvec++; if (hg !== 3'd3 || col !== 2'd1) begin nerr++; $display("FAIL block_setup got h=%0d col=%0d want 3/1", hg, col); end
        row = 3'd2; bg = 1; step();
        nvec++; if (col !== 2'd1) begin nerr++; $display("FAIL block_left got %0d want 1", col); end
        bg = 0; step();
        row = 3'd4; bg = 1; step();
        nvec++; if (col !== 2'd0) begin nerr++; $display("FAIL unblock_left got %0d want 0", col); end
        bg = 0; row = 3'd7; step();
    endtask

    task automatic test_clear();
        bit found = 0;
        new_game();
        pg = 1; step(); pg = 0;
        pc = 1; step(); step(); pc = 0;
        pd = 1; step(); pd = 0;
        nvec++; if ({hg, hc, hd} !== {3'd1, 3'd2, 3'd1}) begin nerr++; $display("FAIL clear_setup got %0d/%0d/%0d want 1/2/1", hg, hc, hd); end
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (pulse === 1'b1) found = 1;
        end
        nvec++; if (!found) begin nerr++; $display("FAIL clear_sync got no pulse want pulse within 8 cycles"); end
        al = 1; step(); al = 0;
        nvec++; if (etat !== 2'd2 || pulse !== 1'b0) begin nerr++; $display("FAIL clear_enter got etat %0d pulse %0b want 2/0", etat, pulse); end
        step();
        nvec++; if (etat !== 2'd1 || pulse !== 1'b0) begin nerr++; $display("FAIL clear_exit got etat %0d pulse %0b want 1/0", etat, pulse); end
        nvec++; if ({hg, hc, hd} !== {3'd0, 3'd1, 3'd0} || score !== 8'd1) begin nerr++; $display("FAIL clear_result got %0d/%0d/%0d s%0d want 0/1/0 s1", hg, hc, hd, score); end
        step(); step();
        nvec++; if (pulse !== 1'b0) begin nerr++; $display("FAIL clear_frozen got pulse %0b want 0", pulse); end
        step();
        nvec++; if (pulse !== 1'b1) begin nerr++; $display("FAIL clear_resume got pulse %0b want 1", pulse); end
    endtask

    task automatic test_land_clear();
        new_game();
        {pg, pc, pd} = 3'b111; step(); {pg, pc, pd} = 3'b000;
        al = 1; step(); al = 0;
        pc = 1; step(); pc = 0;
        nvec++; if ({hg, hc, hd} !== {3'd0, 3'd1, 3'd0} || score !== 8'd1 || etat !== 2'd1) begin
            nerr++; $display("FAIL land_clear got %0d/%0d/%0d s%0d e%0d want 0/1/0 s1 e1", hg, hc, hd, score, etat); end
    endtask

    task automatic test_loss_reset();
        bit bad = 0;
        pe = 1; al = 1; step(); pe = 0; al = 0;
        nvec++; if (etat !== 2'd3) begin nerr++; $display("FAIL loss_enter got %0d want 3", etat); end
        for (int i = 0; i < 20; i++) begin
            step();
            if (pulse !== 1'b0 || score !== 8'd1 || etat !== 2'd3) bad = 1;
        end
        nvec++; if (bad) begin nerr++; $display("FAIL loss_freeze got pulse/score/etat change want frozen 0/1/3"); end
        bs = 1; step(); bs = 0;
        nvec++; if (etat !== 2'd0 || score !== 8'd1) begin nerr++; $display("FAIL loss_restart got e%0d s%0d want e0 s1", etat, score); end
        step();
        bs = 1; step(); bs = 0;
        pg = 1; step(); pg = 0; bd = 1; step(); bd = 0;
        step(); step();
        #3 reset = 1'b1;
        #1;
        nvec++; if ({etat, pulse, col, hg, hc, hd, score} !== {2'd0, 1'b0, 2'd1, 9'd0, 8'd0}) begin
            nerr++; $display("FAIL async_reset got e%0d p%0b c%0d %0d/%0d/%0d s%0d want e0 p0 c1 0/0/0 s0", etat, pulse, col, hg, hc, hd, score); end
        @(posedge clk); #1;
        nvec++; if (pulse !== 1'b0) begin nerr++; $display("FAIL reset_pulse_hold got %0b want 0", pulse); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_saturation();
        new_game();
        pg = 1;
        for (int i = 0; i < 9; i++) step();
        pg = 0;
        nvec++; if (hg !== 3'd7) begin nerr++; $display("FAIL height_sat got %0d want 7", hg); end
        for (int i = 0; i < 256; i++) begin
            al = 1; step(); al = 0; step();
            if (i == 254) begin
                nvec++; if (score !== 8'd255) begin nerr++; $display("FAIL score_255 got %0d want 255", score); end
            end
        end
        nvec++; if (score !== 8'd255 || {hg, hc, hd} !== 9'd0) begin nerr++; $display("FAIL score_sat got s%0d h%0d/%0d/%0d want 255 0/0/0", score, hg, hc, hd); end
    endtask

    task automatic test_random();
        logic [20:0] exp_v, got_v;
        new_game();
        for (int i = 0; i < 800; i++) begin
            bg  = ($urandom % 3) == 0;
            bd  = ($urandom % 3) == 0;
            bs  = ($urandom % 40) == 0;
            pg  = ($urandom % 12) == 0;
            pc  = ($urandom % 12) == 0;
            pd  = ($urandom % 12) == 0;
            al  = ($urandom % 20) == 0;
            pe  = ($urandom % 150) == 0;
            row = 3'($urandom % 8);
            step();
            exp_v = {2'(m_etat), 1'(m_pulse), 2'(m_col), 3'(m_h[0]), 3'(m_h[1]), 3'(m_h[2]), 8'(m_score)};
            got_v = {etat, pulse, col, hg, hc, hd, score};
            nvec++;
            if (got_v !== exp_v) begin
                nerr++;
                $display("FAIL random cyc %0d got e%0d p%0b c%0d h%0d/%0d/%0d s%0d want e%0d p%0d c%0d h%0d/%0d/%0d s%0d",
                         i, etat, pulse, col, hg, hc, hd, score,
                         m_etat, m_pulse, m_col, m_h[0], m_h[1], m_h[2], m_score);
            end
        end
        {bg, bd, bs, pg, pc, pd, al, pe} = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start_pulse();
        test_steering();
        test_blocked();
        test_clear();
        test_land_clear();
        test_loss_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
